// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: skid-buffer state encoding and default word width.
package cpu_pipe_pkg;
  localparam int CPU_WORD_W = 32;

  // Encoding 2'd3 is never entered; decode logic treats it as EMPTY.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;
endpackage

// File: rtl/pipe_reg_en.sv
// WIDTH-bit storage register with load enable; clears to zero on clr.
// Latency 1 cycle from en to q; no flow control of its own.
module pipe_reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages; word visible 1 cycle after accept, 1 xfer/cycle.
// in_ready depends on state only; it drops when main+skid are full. flush empties the buffer.
// Optional PIPE_SKID_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cnt).
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = CPU_WORD_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  skid_state_e      state, state_nxt;
  logic             in_xfer, out_xfer;
  logic             main_ld, skid_ld, main_from_skid;
  logic [WIDTH-1:0] skid_q, main_d;

  assign out_valid = (state == SKID_ONE) || (state == SKID_FULL);
  assign in_ready  = (state != SKID_FULL);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= SKID_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Flush beats every transfer; data registers keep stale contents.
      state_nxt = SKID_EMPTY;
    end else begin
      case (state)
        SKID_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer) begin
            skid_ld   = 1'b1;
            state_nxt = SKID_FULL;
          end else if (out_xfer) begin
            state_nxt = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_xfer) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = SKID_ONE;
          end
        end
        default: begin
          if (in_xfer) begin
            main_ld   = 1'b1;
            state_nxt = SKID_ONE;
          end
        end
      endcase
    end
  end

  pipe_reg_en #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .clr (clr),
    .en  (main_ld),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .clr (clr),
    .en  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
